// File: rtl/la_seq_trg_if.sv
// AXI-stream style beat bundle (data, last, valid/ready) for the logic analyzer stream path.
interface la_seq_trg_if #(
    parameter int DW = 16
);
    logic [DW-1:0] tdata;
    logic          tlast;
    logic          tvalid;
    logic          tready;

    modport master (output tdata, output tlast, output tvalid, input tready);
    modport slave  (input tdata, input tlast, input tvalid, output tready);
endinterface

// File: rtl/la_seq_trg.sv
// Multi-stage sequential trigger: walks up to SN level/edge stages in order and flags the
// beat that completes the sequence, carried through a one-beat register slice.
module la_seq_trg #(
    parameter  int DW = 16,
    parameter  int SN = 4,
    parameter  int PW = 16,
    parameter  int CW = 32,
    localparam int SW = (SN > 1) ? $clog2(SN) : 1
) (
    input  logic             clk,
    input  logic             rst,
    la_seq_trg_if.slave      sti,
    la_seq_trg_if.master     sto,
    input  logic             ctl_rst,
    input  logic             ctl_arm,
    input  logic             cfg_con,
    input  logic [SW:0]      cfg_num,
    input  logic [SN*DW-1:0] cfg_msk,
    input  logic [SN*DW-1:0] cfg_val,
    input  logic [SN*DW-1:0] cfg_pos,
    input  logic [SN*DW-1:0] cfg_neg,
    input  logic [SN*PW-1:0] cfg_cnt,
    input  logic [SN*PW-1:0] cfg_tmo,
    output logic             evn_trg,
    output logic             sts_arm,
    output logic [SW-1:0]    sts_stg,
    output logic [CW-1:0]    sts_trc
);
    typedef enum logic [1:0] {IDLE, ARMED, DONE} state_t;

    state_t        state;
    logic [SW-1:0] stg;
    logic [PW-1:0] hcnt, tcnt;
    logic [DW-1:0] prv;
    logic          pvl;
    logic [CW-1:0] trc;

    logic          beat;
    logic [DW-1:0] msk, val, pos, neg;
    logic [PW-1:0] cnt_eff, tmo, hcnt_nx, tcnt_nx;
    logic [SW:0]   num_eff;
    logic          lvl, edg, hit, sat, last_stg, fire;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [SW:0] clamp_num(input logic [SW:0] n);
        if (n == '0)
            return (SW+1)'(1);
        else if (n > (SW+1)'(SN))
            return (SW+1)'(SN);
        else
            return n;
    endfunction

    assign sti.tready = ~sto.tvalid | sto.tready;
    assign beat       = sti.tvalid & sti.tready;

    always_comb begin
        msk      = cfg_msk[stg*DW +: DW];
        val      = cfg_val[stg*DW +: DW];
        pos      = cfg_pos[stg*DW +: DW];
        neg      = cfg_neg[stg*DW +: DW];
        tmo      = cfg_tmo[stg*PW +: PW];
        cnt_eff  = (cfg_cnt[stg*PW +: PW] == '0) ? PW'(1) : cfg_cnt[stg*PW +: PW];
        num_eff  = clamp_num(cfg_num);
        hcnt_nx  = hcnt + 1'b1;
        tcnt_nx  = tcnt + 1'b1;
        lvl      = ((sti.tdata ^ val) & msk) == '0;
        // Edges need a previous sample; the first beat after a soft reset cannot edge-hit.
        edg      = pvl & ((|(pos & sti.tdata & ~prv)) | (|(neg & ~sti.tdata & prv)));
        hit      = lvl & (((pos | neg) == '0) | edg);
        sat      = hit & (hcnt_nx >= cnt_eff);
        last_stg = {1'b0, stg} >= (num_eff - 1'b1);
        fire     = beat & ~ctl_arm & (state == ARMED) & sat & last_stg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            stg        <= '0;
            hcnt       <= '0;
            tcnt       <= '0;
            prv        <= '0;
            pvl        <= 1'b0;
            trc        <= '0;
            sto.tdata  <= '0;
            sto.tlast  <= 1'b0;
            sto.tvalid <= 1'b0;
            evn_trg    <= 1'b0;
        end else if (ctl_rst) begin
            state      <= IDLE;
            stg        <= '0;
            hcnt       <= '0;
            tcnt       <= '0;
            pvl        <= 1'b0;
            trc        <= '0;
            sto.tvalid <= 1'b0;
            evn_trg    <= 1'b0;
        end else begin
            if (beat) begin
                prv        <= sti.tdata;
                pvl        <= 1'b1;
                sto.tdata  <= sti.tdata;
                sto.tlast  <= sti.tlast;
                sto.tvalid <= 1'b1;
                evn_trg    <= fire;
            end else if (sto.tready) begin
                sto.tvalid <= 1'b0;
                evn_trg    <= 1'b0;
            end

            if (ctl_arm) begin
                state <= ARMED;
                stg   <= '0;
                hcnt  <= '0;
                tcnt  <= '0;
            end else if (beat && state == ARMED) begin
                if (sat) begin
                    hcnt <= '0;
                    tcnt <= '0;
                    if (!last_stg) begin
                        stg <= stg + 1'b1;
                    end else begin
                        stg   <= '0;
                        trc   <= sat_inc(trc);
                        state <= cfg_con ? ARMED : DONE;
                    end
                end else begin
                    if (hit)
                        hcnt <= hcnt_nx;
                    // A satisfying beat never reaches here, so it always beats a timeout.
                    if (stg != '0 && tmo != '0) begin
                        if (tcnt_nx >= tmo) begin
                            stg  <= '0;
                            hcnt <= '0;
                            tcnt <= '0;
                        end else begin
                            tcnt <= tcnt_nx;
                        end
                    end
                end
            end
        end
    end

    assign sts_arm = (state == ARMED);
    assign sts_stg = stg;
    assign sts_trc = trc;
endmodule
